// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Latches the winner's payload, holds the transfer until PREADY or timeout, then returns the response.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        sel,
  output logic                        wr_in,
  output logic [ADDR_W-1:0]           addr_in,
  output logic [DATA_W-1:0]           data_in,
  input  logic                        PREADY,
  input  logic [DATA_W-1:0]           prdata
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [GW-1:0]      last_grant, last_grant_nxt;
  logic [TW-1:0]      timer, timer_nxt;
  logic [NUM_REQ-1:0] req_ready_nxt, rsp_valid_nxt;
  logic [DATA_W-1:0]  rsp_rdata_nxt, data_in_nxt;
  logic               rsp_err_nxt, sel_nxt, wr_in_nxt;
  logic [ADDR_W-1:0]  addr_in_nxt;
  logic               found;
  logic [GW-1:0]      cand, winner;

  // Round-robin search starting one past the last grant.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((32'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    timer_nxt      = timer;
    req_ready_nxt  = '0;
    rsp_valid_nxt  = '0;
    rsp_rdata_nxt  = rsp_rdata;
    rsp_err_nxt    = rsp_err;
    sel_nxt        = sel;
    wr_in_nxt      = wr_in;
    addr_in_nxt    = addr_in;
    data_in_nxt    = data_in;
    case (state)
      S_IDLE: begin
        sel_nxt   = 1'b0;
        timer_nxt = '0;
        if (found) begin
          state_nxt             = S_BUSY;
          sel_nxt               = 1'b1;
          wr_in_nxt             = req_wr[winner];
          addr_in_nxt           = req_addr[32'(winner)*ADDR_W +: ADDR_W];
          data_in_nxt           = req_wdata[32'(winner)*DATA_W +: DATA_W];
          last_grant_nxt        = winner;
          req_ready_nxt[winner] = 1'b1;
        end
      end
      S_BUSY: begin
        timer_nxt = timer + TW'(1);
        // PREADY takes priority over a coincident timeout.
        if (PREADY) begin
          state_nxt                 = S_DONE;
          sel_nxt                   = 1'b0;
          rsp_valid_nxt[last_grant] = 1'b1;
          rsp_rdata_nxt             = wr_in ? '0 : prdata;
          rsp_err_nxt               = 1'b0;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_nxt                 = S_DONE;
          sel_nxt                   = 1'b0;
          rsp_valid_nxt[last_grant] = 1'b1;
          rsp_rdata_nxt             = '0;
          rsp_err_nxt               = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt     = S_IDLE;
        sel_nxt       = 1'b0;
        timer_nxt     = '0;
        rsp_rdata_nxt = '0;
        rsp_err_nxt   = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        sel_nxt   = 1'b0;
        timer_nxt = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      timer      <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      sel        <= 1'b0;
      wr_in      <= 1'b0;
      addr_in    <= '0;
      data_in    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      timer      <= timer_nxt;
      req_ready  <= req_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      rsp_err    <= rsp_err_nxt;
      sel        <= sel_nxt;
      wr_in      <= wr_in_nxt;
      addr_in    <= addr_in_nxt;
      data_in    <= data_in_nxt;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: directed scenarios push expected responses,
// a negedge monitor pops and compares them whenever rsp_valid fires.
module tb_apb_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_wr, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, data_in, prdata;
  logic            rsp_err, sel, wr_in, PREADY;
  logic [AW-1:0]   addr_in;

  typedef struct {
    int unsigned   idx;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Slave model knobs: delay = BUSY cycle index to assert PREADY (-1: never).
  int            delay = -1;
  logic [DW-1:0] slave_base = '0;
  logic          add_addr = 1'b0;
  int            bcnt = 0;

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sel(sel), .wr_in(wr_in), .addr_in(addr_in), .data_in(data_in),
    .PREADY(PREADY), .prdata(prdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: drives PREADY/prdata on the falling edge while sel is high.
  initial begin
    PREADY = 1'b0;
    prdata = '0;
    forever begin
      @(negedge clk);
      if (sel) begin
        PREADY = (delay >= 0) && (bcnt == delay);
        prdata = add_addr ? slave_base + DW'(addr_in) : slave_base;
        bcnt++;
      end else begin
        PREADY = 1'b0;
        bcnt   = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err",   64'(rsp_err),   64'(e.err));
        end
      end
    end
  end

  task automatic push(input int unsigned idx, input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e.idx = idx; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  // Waits (bounded) for a req_ready pulse; returns it and the cycle it was seen.
  task automatic wait_grant(output logic [N-1:0] g, output int at);
    g = '0; at = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (req_ready != '0) begin g = req_ready; at = cyc; break; end
    end
    if (at < 0) check("grant_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'(0));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [N-1:0] g;
    int at, prev, cnt;
    rst = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    do_reset();
    #1;
    check("reset_sel",   64'(sel), 64'(0));
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_rsp",   64'({rsp_valid, rsp_err}), 64'(0));
    check("reset_bus",   64'({wr_in, addr_in}), 64'(0));

    // 1: single read, PREADY on third BUSY cycle.
    delay = 2; add_addr = 1'b0; slave_base = 32'hDEADBEEF;
    push(0, 32'hDEADBEEF, 1'b0);
    @(negedge clk); set_req(0, 1'b0, 12'h004, 32'h0);
    wait_grant(g, at);
    req_valid = '0;
    check("t1_ready", 64'(g), 64'h1);
    check("t1_bus",   64'({sel, wr_in, addr_in}), 64'({1'b1, 1'b0, 12'h004}));
    drain();

    // 2: all requesting, immediate PREADY: grants 0,1,2,3,0 three cycles apart.
    do_reset();
    delay = 0; add_addr = 1'b1; slave_base = 32'hC0DE0000;
    for (int i = 0; i < 5; i++) push(i % 4, 32'hC0DE0000 + 32'(12'h100 + 12'(i % 4)), 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 12'(12'h100 + 12'(i)), 32'h0);
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, at);
      check("t2_order", 64'(g), 64'(1) << (k % 4));
      if (prev >= 0) check("t2_spacing", 64'(at - prev), 64'(3));
      prev = at;
    end
    req_valid = '0;
    drain();

    // 3: write from requester 2, payload held until PREADY.
    do_reset();
    delay = 3; add_addr = 1'b0; slave_base = 32'hFFFFFFFF;
    push(2, 32'h0, 1'b0);
    @(negedge clk); set_req(2, 1'b1, 12'h010, 32'h12345678);
    wait_grant(g, at);
    req_valid = '0; req_addr = '0; req_wdata = '0;
    check("t3_ready", 64'(g), 64'h4);
    for (int k = 0; k < 4; k++) begin
      check("t3_bus", {sel, wr_in, addr_in, data_in}, {18'h0, 1'b1, 1'b1, 12'h010, 32'h12345678});
      @(posedge clk); #1;
    end
    check("t3_sel_drop", 64'(sel), 64'(0));
    drain();

    // 4: timeout with PREADY never asserted.
    do_reset();
    delay = -1; slave_base = 32'hA5A5A5A5;
    push(1, 32'h0, 1'b1);
    @(negedge clk); set_req(1, 1'b0, 12'h020, 32'h0);
    wait_grant(g, at);
    req_valid = '0;
    cnt = 1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (sel) cnt++; else break;
    end
    check("t4_sel_cycles", 64'(cnt), 64'(8));
    drain();

    // 5: PREADY coincides with the timeout cycle.
    do_reset();
    delay = 7; slave_base = 32'h5A5A0F0F;
    push(3, 32'h5A5A0F0F, 1'b0);
    @(negedge clk); set_req(3, 1'b0, 12'h030, 32'h0);
    wait_grant(g, at);
    req_valid = '0;
    check("t5_ready", 64'(g), 64'h8);
    drain();

    // 6: reset mid-BUSY aborts silently; req0 wins first afterwards.
    do_reset();
    delay = -1;
    @(negedge clk); set_req(2, 1'b0, 12'h040, 32'h0);
    wait_grant(g, at);
    req_valid = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("t6_sel_drop", 64'(sel), 64'(0));
    @(negedge clk); rst = 1'b1;
    repeat (12) @(posedge clk);
    delay = 0; slave_base = 32'h600D600D;
    push(0, 32'h600D600D, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0, 12'h050, 32'h0);
    set_req(1, 1'b0, 12'h060, 32'h0);
    wait_grant(g, at);
    req_valid = '0;
    check("t6_first_grant", 64'(g), 64'h1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
